// File: rtl/qarma128_pkg.sv
// Shared QARMA-128 tweakey constants, block type and cell helpers.
// QARMA_TK_PARITY_EN adds a per-cell parity field to tk_blk_t.
package qarma128_pkg;

  localparam int unsigned CELL_W = 8;
  localparam int unsigned NCELL  = 16;
  localparam int unsigned BLK_W  = CELL_W * NCELL;

  // Forward tweak permutation h: new cell i takes old cell H_PERM[i].
  localparam int unsigned H_PERM [NCELL] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
  localparam int unsigned H_INV  [NCELL] = '{4, 5, 6, 7, 11, 1, 0, 8, 12, 13, 14, 15, 9, 10, 2, 3};

  // Bit 15 corresponds to cell 0: LFSR cells {0,1,3,4,8,11,13}.
  localparam logic [NCELL-1:0] OMEGA_CELLS = 16'hD894;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } skid_state_e;

  typedef struct packed {
    logic [BLK_W-1:0] state;
    logic [BLK_W-1:0] tweak;
    logic [BLK_W-1:0] tk;
`ifdef QARMA_TK_PARITY_EN
    logic [NCELL-1:0] par;
`endif
  } tk_blk_t;

  function automatic logic [CELL_W-1:0] omega_inv(input logic [CELL_W-1:0] y);
    return {y[6:0], y[7] ^ y[1]};
  endfunction

  // Even parity per cell; bit 15 belongs to cell 0.
  function automatic logic [NCELL-1:0] cell_parity(input logic [BLK_W-1:0] v);
    logic [NCELL-1:0] p;
    p = '0;
    for (int i = 0; i < NCELL; i++) begin
      p[i] = ^v[i*CELL_W +: CELL_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/qarma128_inv_tk_stage_if.sv
// Upstream/downstream handshake and data bundle of the inverse tweakey stage.
// QARMA_TK_PARITY_EN adds out_tk_par.
interface qarma128_inv_tk_stage_if;
  import qarma128_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_state;
  logic [BLK_W-1:0] in_tweak;
  logic [BLK_W-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_state;
  logic [BLK_W-1:0] out_tweak;
  logic [BLK_W-1:0] out_tk;
`ifdef QARMA_TK_PARITY_EN
  logic [NCELL-1:0] out_tk_par;
`endif

  modport master (
    output in_valid, in_state, in_tweak, in_key, out_ready,
    input  in_ready, out_valid, out_state, out_tweak, out_tk
`ifdef QARMA_TK_PARITY_EN
    , input out_tk_par
`endif
  );

  modport slave (
    input  in_valid, in_state, in_tweak, in_key, out_ready,
    output in_ready, out_valid, out_state, out_tweak, out_tk
`ifdef QARMA_TK_PARITY_EN
    , output out_tk_par
`endif
  );

endinterface

// File: rtl/qarma128_tweak_inv_update.sv
// Combinational inverse tweak update: omega^-1 on the LFSR cells, then h^-1.
module qarma128_tweak_inv_update
  import qarma128_pkg::*;
(
  input  logic [BLK_W-1:0] tweak,
  output logic [BLK_W-1:0] tweak_upd
);

  logic [BLK_W-1:0] mixed;

  always_comb begin
    mixed = '0;
    for (int i = 0; i < NCELL; i++) begin
      if (OMEGA_CELLS[NCELL-1-i]) begin
        mixed[(NCELL-1-i)*CELL_W +: CELL_W] = omega_inv(tweak[(NCELL-1-i)*CELL_W +: CELL_W]);
      end else begin
        mixed[(NCELL-1-i)*CELL_W +: CELL_W] = tweak[(NCELL-1-i)*CELL_W +: CELL_W];
      end
    end
  end

  always_comb begin
    tweak_upd = '0;
    for (int j = 0; j < NCELL; j++) begin
      tweak_upd[(NCELL-1-j)*CELL_W +: CELL_W] = mixed[(NCELL-1-H_INV[j])*CELL_W +: CELL_W];
    end
  end

endmodule

// File: rtl/qarma128_inv_tk_stage.sv
// Registered tweakey stage ahead of a QARMA-128 inverse round, with 2-entry skid.
// QARMA_TK_PARITY_EN adds registered per-cell parity of out_tk.
module qarma128_inv_tk_stage
  import qarma128_pkg::*;
#(
  parameter logic [BLK_W-1:0] RC        = '0,
  parameter bit               DO_UPDATE = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  qarma128_inv_tk_stage_if.slave bus
);

  skid_state_e      state_q, state_d;
  tk_blk_t          r_q, r_d, s_q, s_d;
  tk_blk_t          blk_in;
  logic [BLK_W-1:0] tweak_step;
  logic [BLK_W-1:0] tweak_new;
  logic             push, pop;

  qarma128_tweak_inv_update u_upd (
    .tweak     (bus.in_tweak),
    .tweak_upd (tweak_step)
  );

  assign tweak_new = DO_UPDATE ? tweak_step : bus.in_tweak;

  always_comb begin
    blk_in       = '0;
    blk_in.state = bus.in_state;
    blk_in.tweak = tweak_new;
    blk_in.tk    = tweak_new ^ bus.in_key ^ RC;
`ifdef QARMA_TK_PARITY_EN
    blk_in.par   = cell_parity(blk_in.tk);
`endif
  end

  // in_ready depends only on registered state and rst, never on out_ready.
  assign bus.in_ready  = !rst && (state_q != StFull);
  assign bus.out_valid = (state_q != StEmpty);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          r_d     = blk_in;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          r_d = blk_in;
        end else if (push) begin
          s_d     = blk_in;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          r_d     = s_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      r_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
    end
  end

  assign bus.out_state = r_q.state;
  assign bus.out_tweak = r_q.tweak;
  assign bus.out_tk    = r_q.tk;
`ifdef QARMA_TK_PARITY_EN
  assign bus.out_tk_par = r_q.par;
`endif

endmodule

// File: tb/tb_qarma128_inv_tk_stage.sv
// Directed self-checking bench for qarma128_inv_tk_stage (update and pass-through instances).
module tb_qarma128_inv_tk_stage;

  localparam logic [127:0] RC_B  = 128'h243F6A88_85A308D3_13198A2E_03707344;
  localparam logic [127:0] T_A   = 128'h0123456789ABCDEF_0123456789ABCDEF;
  // Hand-derived omega^-1 then h^-1 of T_A.
  localparam logic [127:0] TP_A  = 128'h13ABCDEF_CF470202_8956CDEF_234545CF;
  localparam logic [127:0] K_A   = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] K_B   = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
  localparam logic [127:0] ONES  = {128{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int unsigned h_fwd [16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};

  qarma128_inv_tk_stage_if a ();
  qarma128_inv_tk_stage_if b ();

  qarma128_inv_tk_stage #(
    .RC        ('0),
    .DO_UPDATE (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  qarma128_inv_tk_stage #(
    .RC        (RC_B),
    .DO_UPDATE (1'b0)
  ) dut_noupd (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inverse update by scattering through the forward permutation.
  function automatic logic [127:0] model_inv(input logic [127:0] t);
    logic [7:0]   c [16];
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      c[i] = t[127-8*i -: 8];
      if (i inside {0, 1, 3, 4, 8, 11, 13}) c[i] = {c[i][6:0], c[i][7] ^ c[i][1]};
    end
    for (int i = 0; i < 16; i++) r[127-8*h_fwd[i] -: 8] = c[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [127:0] s, input logic [127:0] t,
                         input logic [127:0] k);
    a.in_valid = v;
    a.in_state = s;
    a.in_tweak = t;
    a.in_key   = k;
  endtask

  initial begin
    drive_a(1'b0, '0, '0, '0);
    a.out_ready = 1'b0;
    b.in_valid  = 1'b0;
    b.in_state  = '0;
    b.in_tweak  = '0;
    b.in_key    = '0;
    b.out_ready = 1'b1;

    // Reset behaviour
    step();
    check("ready_in_rst", a.in_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("rst_valid", a.out_valid, 1'b0);
    check("rst_ready", a.in_ready, 1'b1);
    check("rst_tk", a.out_tk, '0);
    check("rst_tweak", a.out_tweak, '0);
    check("rst_state", a.out_state, '0);

    // 1: single block, latency 1
    a.out_ready = 1'b1;
    drive_a(1'b1, 128'h5555, T_A, '0);
    step();
    drive_a(1'b0, '0, '0, '0);
    check("t1_valid", a.out_valid, 1'b1);
    check("t1_tweak", a.out_tweak, TP_A);
    check("t1_tweak_model", a.out_tweak, model_inv(T_A));
    check("t1_tk", a.out_tk, TP_A);
    check("t1_state", a.out_state, 128'h5555);
    step();
    check("t1_drain", a.out_valid, 1'b0);

    // 2: back-pressure, skid fill and FIFO release
    a.out_ready = 1'b0;
    drive_a(1'b1, 128'hA, T_A, K_A);
    step();
    check("t2_ready_one", a.in_ready, 1'b1);
    drive_a(1'b1, 128'hB, '0, K_B);
    step();
    check("t2_ready_full", a.in_ready, 1'b0);
    check("t2_hold_tk0", a.out_tk, TP_A ^ K_A);
    drive_a(1'b1, 128'hC, ONES, ONES);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_stall_valid", a.out_valid, 1'b1);
      check("t2_stall_tk", a.out_tk, TP_A ^ K_A);
      check("t2_stall_state", a.out_state, 128'hA);
    end
    drive_a(1'b0, '0, '0, '0);
    a.out_ready = 1'b1;
    step();
    check("t2_rel_b_valid", a.out_valid, 1'b1);
    check("t2_rel_b_state", a.out_state, 128'hB);
    check("t2_rel_b_tk", a.out_tk, K_B);
    check("t2_rel_b_tweak", a.out_tweak, '0);
    step();
    check("t2_rel_empty", a.out_valid, 1'b0);

    // 3: continuous stream of 100 blocks
    for (int i = 0; i < 100; i++) begin
      logic [31:0]  w;
      logic [127:0] tw, ky;
      w  = 32'h9E3779B9 * i;
      tw = {w, w ^ 32'hA5A5A5A5, ~w, w + 32'h1};
      ky = {~w, w, w ^ 32'h0F0F0F0F, 32'h12345678};
      drive_a(1'b1, {96'h0, w}, tw, ky);
      check("t3_in_ready", a.in_ready, 1'b1);
      step();
      check("t3_valid", a.out_valid, 1'b1);
      check("t3_tk", a.out_tk, model_inv(tw) ^ ky);
      check("t3_state", a.out_state, {96'h0, w});
    end
    drive_a(1'b0, '0, '0, '0);
    step();
    check("t3_drain", a.out_valid, 1'b0);

    // 4: pass-through instance with nonzero RC
    b.in_valid = 1'b1;
    b.in_tweak = ONES;
    b.in_key   = ONES;
    step();
    check("t4_tweak", b.out_tweak, ONES);
    check("t4_tk_tk", b.out_tk, RC_B);
    b.in_key = '0;
    step();
    check("t4_tk_not_rc", b.out_tk, ~RC_B);
    b.in_tweak = T_A;
    step();
    check("t4_tweak_pass", b.out_tweak, T_A);
    check("t4_tk_pass", b.out_tk, T_A ^ RC_B);
    b.in_valid = 1'b0;

    // 5: reset while full
    a.out_ready = 1'b0;
    drive_a(1'b1, 128'h1, T_A, K_A);
    step();
    drive_a(1'b1, 128'h2, T_A, K_B);
    step();
    check("t5_full", a.in_ready, 1'b0);
    rst = 1'b1;
    drive_a(1'b1, 128'h3, T_A, K_A);
    step();
    check("t5_rst_valid", a.out_valid, 1'b0);
    check("t5_rst_tk", a.out_tk, '0);
    check("t5_rst_ready", a.in_ready, 1'b0);
    rst = 1'b0;
    drive_a(1'b0, '0, '0, '0);
    a.out_ready = 1'b1;
    #1;
    check("t5_ready_after", a.in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_stale", a.out_valid, 1'b0);
    end

`ifdef QARMA_TK_PARITY_EN
    // 6: per-cell parity of out_tk
    drive_a(1'b1, '0, '0, {8'h07, 120'h0});
    step();
    check("t6_par_cell0", a.out_tk_par, 16'h8000);
    drive_a(1'b1, '0, '0, {16{8'h01}});
    step();
    check("t6_par_all", a.out_tk_par, 16'hFFFF);
    drive_a(1'b0, '0, '0, '0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
